ibex_hpm_counter_bank: RTL and testbench

- Parametrised bank of machine hardware performance-monitor counters (mhpmcounter3.., mhpmcounter3h.., mhpmevent3.., mcountinhibit bits).
- Replaces fixed-count counter instantiation in the CS register file. Counter count, counter width and event-vector width are all generic.
- Adds an optional sticky overflow/interrupt facility.
- Sits beside the CSR block: decodes its own CSR addresses, answers reads combinationally and commits writes on the clock edge.

---
 rtl/ibex_hpm_counter_bank_pkg.sv | 16 +
 rtl/ibex_hpm_counter_bank_counter.sv | 47 ++++
 rtl/ibex_hpm_counter_bank.sv | 138 +++++++++++++
 tb/tb_ibex_hpm_counter_bank.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ibex_hpm_counter_bank_pkg.sv
// Shared CSR numbering and address bases for the HPM counter bank.
package ibex_hpm_counter_bank_pkg;

  typedef enum logic [11:0] {
    CSR_MCOUNTINHIBIT = 12'h320,
    CSR_MHPMOVF       = 12'h7C2,
    CSR_MHPMOVFEN     = 12'h7C3
  } csr_num_e;

  parameter int unsigned HPM_FIRST_IDX = 3;

  parameter logic [11:0] CSR_OFF_MHPMCOUNTER  = 12'hB03;
  parameter logic [11:0] CSR_OFF_MHPMCOUNTERH = 12'hB83;
  parameter logic [11:0] CSR_OFF_MHPMEVENT    = 12'h323;

endpackage

// File: rtl/ibex_hpm_counter_bank_counter.sv
// Single HPM counter: CSR write of either half beats the increment in the
// same cycle; wrap_o pulses when an increment rolls all-ones over to zero.
module ibex_hpm_counter #(
  parameter int unsigned CounterWidth = 40
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        inc_i,
  input  logic        we_lo_i,
  input  logic        we_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] value_o,
  output logic        wrap_o
);

  logic [CounterWidth-1:0] cnt_q, cnt_d;
  logic [63:0]             cur64, nxt64;
  logic                    we_hi_eff;

  // Narrow counters have no high half, so a high write neither lands nor stalls counting.
  assign we_hi_eff = (CounterWidth > 32) ? we_hi_i : 1'b0;
  assign cur64     = 64'(cnt_q);

  always_comb begin
    nxt64 = cur64;
    if (we_lo_i) begin
      nxt64 = {cur64[63:32], wdata_i};
    end else if (we_hi_eff) begin
      nxt64 = {wdata_i, cur64[31:0]};
    end else if (inc_i) begin
      nxt64 = cur64 + 64'd1;
    end
    cnt_d = nxt64[CounterWidth-1:0];
  end

  assign wrap_o  = inc_i & ~we_lo_i & ~we_hi_eff & (&cnt_q);
  assign value_o = cur64;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ibex_hpm_counter_bank.sv
// Bank of machine HPM counters with CSR decode, inhibit and event selection.
// Optional sticky overflow + interrupt when IBEX_HPM_OVF_IRQ_EN is defined.
module ibex_hpm_counter_bank
  import ibex_hpm_counter_bank_pkg::*;
#(
  parameter int unsigned NumCounters  = 8,
  parameter int unsigned CounterWidth = 40,
  parameter int unsigned NumEvents    = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 csr_we_i,
  input  logic [11:0]          csr_addr_i,
  input  logic [31:0]          csr_wdata_i,
  output logic [31:0]          csr_rdata_o,
  output logic                 csr_hit_o,
  input  logic [NumEvents-1:0] event_i,
  output logic                 irq_ovf_o
);

  logic [NumCounters-1:0] inhibit_q;
  logic [NumEvents-1:0]   evt_q [NumCounters];
  logic [NumCounters-1:0] we_lo, we_hi, we_evt, inc, wrap;
  logic [63:0]            cnt_val [NumCounters];
  logic                   we_inh;
`ifdef IBEX_HPM_OVF_IRQ_EN
  logic [NumCounters-1:0] ovf_q, ovfen_q;
  logic                   irq_q;
  logic                   we_ovf, we_ovfen;
`endif

  always_comb begin
    csr_hit_o   = 1'b0;
    csr_rdata_o = '0;
    we_inh      = 1'b0;
    we_lo       = '0;
    we_hi       = '0;
    we_evt      = '0;
    inc         = '0;
`ifdef IBEX_HPM_OVF_IRQ_EN
    we_ovf      = 1'b0;
    we_ovfen    = 1'b0;
`endif
    if (csr_addr_i == CSR_MCOUNTINHIBIT) begin
      csr_hit_o   = 1'b1;
      csr_rdata_o = 32'(inhibit_q) << HPM_FIRST_IDX;
      we_inh      = csr_we_i;
    end
`ifdef IBEX_HPM_OVF_IRQ_EN
    if (csr_addr_i == CSR_MHPMOVF) begin
      csr_hit_o   = 1'b1;
      csr_rdata_o = 32'(ovf_q) << HPM_FIRST_IDX;
      we_ovf      = csr_we_i;
    end
    if (csr_addr_i == CSR_MHPMOVFEN) begin
      csr_hit_o   = 1'b1;
      csr_rdata_o = 32'(ovfen_q) << HPM_FIRST_IDX;
      we_ovfen    = csr_we_i;
    end
`endif
    for (int unsigned k = 0; k < NumCounters; k++) begin
      // Event selection and inhibit use the registered values, so writes apply next cycle.
      inc[k] = ~inhibit_q[k] & (|(evt_q[k] & event_i));
      if (csr_addr_i == CSR_OFF_MHPMCOUNTER + 12'(k)) begin
        csr_hit_o   = 1'b1;
        csr_rdata_o = cnt_val[k][31:0];
        we_lo[k]    = csr_we_i;
      end
      if (csr_addr_i == CSR_OFF_MHPMCOUNTERH + 12'(k)) begin
        csr_hit_o   = 1'b1;
        csr_rdata_o = cnt_val[k][63:32];
        we_hi[k]    = csr_we_i;
      end
      if (csr_addr_i == CSR_OFF_MHPMEVENT + 12'(k)) begin
        csr_hit_o   = 1'b1;
        csr_rdata_o = 32'(evt_q[k]);
        we_evt[k]   = csr_we_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      inhibit_q <= '1;
      for (int unsigned k = 0; k < NumCounters; k++) begin
        evt_q[k] <= '0;
      end
    end else begin
      if (we_inh) begin
        inhibit_q <= csr_wdata_i[HPM_FIRST_IDX +: NumCounters];
      end
      for (int unsigned k = 0; k < NumCounters; k++) begin
        if (we_evt[k]) begin
          evt_q[k] <= csr_wdata_i[NumEvents-1:0];
        end
      end
    end
  end

  for (genvar k = 0; k < NumCounters; k++) begin : g_cnt
    ibex_hpm_counter #(
      .CounterWidth(CounterWidth)
    ) u_cnt (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .inc_i   (inc[k]),
      .we_lo_i (we_lo[k]),
      .we_hi_i (we_hi[k]),
      .wdata_i (csr_wdata_i),
      .value_o (cnt_val[k]),
      .wrap_o  (wrap[k])
    );
  end

`ifdef IBEX_HPM_OVF_IRQ_EN
  // A wrap in the same cycle as a software clear keeps the bit set.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ovf_q   <= '0;
      ovfen_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      ovf_q <= (ovf_q & ~(we_ovf ? csr_wdata_i[HPM_FIRST_IDX +: NumCounters] : '0)) | wrap;
      if (we_ovfen) begin
        ovfen_q <= csr_wdata_i[HPM_FIRST_IDX +: NumCounters];
      end
      irq_q <= |(ovf_q & ovfen_q);
    end
  end

  assign irq_ovf_o = irq_q;
`else
  logic unused_wrap;
  assign unused_wrap = ^wrap;
  assign irq_ovf_o   = 1'b0;
`endif

endmodule

// File: tb/tb_ibex_hpm_counter_bank.sv
// Bench for ibex_hpm_counter_bank: directed scenarios plus random CSR traffic
// compared every cycle against an arithmetic model of the counter bank.
module tb_ibex_hpm_counter_bank;

  localparam int NC = 4;
  localparam int CW = 40;
  localparam int NE = 16;
  localparam longint unsigned MASK = (64'd1 << CW) - 64'd1;

  logic          clk = 1'b0;
  logic          rst;
  logic          csr_we;
  logic [11:0]   csr_addr;
  logic [31:0]   csr_wdata;
  logic [31:0]   csr_rdata;
  logic          csr_hit;
  logic [NE-1:0] ev;
  logic          irq;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  ibex_hpm_counter_bank #(
    .NumCounters (NC),
    .CounterWidth(CW),
    .NumEvents   (NE)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .csr_we_i   (csr_we),
    .csr_addr_i (csr_addr),
    .csr_wdata_i(csr_wdata),
    .csr_rdata_o(csr_rdata),
    .csr_hit_o  (csr_hit),
    .event_i    (ev),
    .irq_ovf_o  (irq)
  );

  // Reference model state
  longint unsigned m_cnt [NC];
  logic [NE-1:0]   m_evt [NC];
  logic [NC-1:0]   m_inh, m_ovf, m_ovfen;
  logic            m_irq;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic m_hit(input logic [11:0] a);
    if (a == 12'h320) return 1'b1;
`ifdef IBEX_HPM_OVF_IRQ_EN
    if (a == 12'h7C2 || a == 12'h7C3) return 1'b1;
`endif
    for (int k = 0; k < NC; k++) begin
      if (a == 12'(12'hB03 + k) || a == 12'(12'hB83 + k) || a == 12'(12'h323 + k)) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    if (a == 12'h320) return 32'(m_inh) << 3;
`ifdef IBEX_HPM_OVF_IRQ_EN
    if (a == 12'h7C2) return 32'(m_ovf) << 3;
    if (a == 12'h7C3) return 32'(m_ovfen) << 3;
`endif
    for (int k = 0; k < NC; k++) begin
      if (a == 12'(12'hB03 + k)) return m_cnt[k][31:0];
      if (a == 12'(12'hB83 + k)) return m_cnt[k][63:32];
      if (a == 12'(12'h323 + k)) return 32'(m_evt[k]);
    end
    return 32'h0;
  endfunction

  always @(posedge clk or posedge rst) begin : model
    logic [NC-1:0] wrapped;
    if (rst) begin
      for (int k = 0; k < NC; k++) begin
        m_cnt[k] = 0;
        m_evt[k] = '0;
      end
      m_inh = '1; m_ovf = '0; m_ovfen = '0; m_irq = 1'b0;
    end else begin
      wrapped = '0;
`ifdef IBEX_HPM_OVF_IRQ_EN
      m_irq = |(m_ovf & m_ovfen);
`else
      m_irq = 1'b0;
`endif
      for (int k = 0; k < NC; k++) begin
        if (csr_we && csr_addr == 12'(12'hB03 + k)) begin
          m_cnt[k] = (((m_cnt[k] >> 32) << 32) | 64'(csr_wdata)) & MASK;
        end else if (csr_we && csr_addr == 12'(12'hB83 + k) && CW > 32) begin
          m_cnt[k] = ((64'(csr_wdata) << 32) | (m_cnt[k] & 64'hFFFF_FFFF)) & MASK;
        end else if (!m_inh[k] && (m_evt[k] & ev) != '0) begin
          if (m_cnt[k] == MASK) begin
            m_cnt[k] = 0;
            wrapped[k] = 1'b1;
          end else begin
            m_cnt[k] = m_cnt[k] + 1;
          end
        end
      end
`ifdef IBEX_HPM_OVF_IRQ_EN
      if (csr_we && csr_addr == 12'h7C2) m_ovf = m_ovf & ~csr_wdata[3 +: NC];
      m_ovf = m_ovf | wrapped;
      if (csr_we && csr_addr == 12'h7C3) m_ovfen = csr_wdata[3 +: NC];
`endif
      if (csr_we && csr_addr == 12'h320) m_inh = csr_wdata[3 +: NC];
      for (int k = 0; k < NC; k++) begin
        if (csr_we && csr_addr == 12'(12'h323 + k)) m_evt[k] = csr_wdata[NE-1:0];
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("hit", 64'(csr_hit), 64'(m_hit(csr_addr)));
      chk("rdata", 64'(csr_rdata), 64'(m_read(csr_addr)));
      chk("irq", 64'(irq), 64'(m_irq));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    csr_we = 1'b1; csr_addr = a; csr_wdata = d;
    tick();
    csr_we = 1'b0;
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string name);
    csr_we = 1'b0; csr_addr = a;
    #1;
    chk(name, 64'(csr_rdata), 64'(exp));
  endtask

  initial begin
    logic [11:0] a;
    rst = 1'b0; csr_we = 1'b0; csr_addr = 12'h0; csr_wdata = 32'h0; ev = '0;
    #2 rst = 1'b1;
    chk_en = 1'b1;
    #1;
    rd(12'h320, 32'h78, "inhibit_reset");
    chk("irq_reset", 64'(irq), 64'd0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;

    // Idle with every event asserted: inhibit holds all counters at zero
    ev = '1;
    repeat (10) tick();
    rd(12'hB03, 32'h0, "idle_cnt3");
    rd(12'hB06, 32'h0, "idle_cnt6");
    ev = '0;

    // Overlapping selected events count once per cycle
    wr(12'h323, 32'h5);
    wr(12'h320, 32'h0);
    ev = 16'h1; repeat (3) tick();
    ev = 16'h5; repeat (2) tick();
    ev = '0;
    rd(12'hB03, 32'h5, "event_or_count");

`ifdef IBEX_HPM_OVF_IRQ_EN
    wr(12'h7C3, 32'h8);
`endif
    wr(12'hB83, 32'hFF);
    wr(12'hB03, 32'hFFFF_FFFE);
    ev = 16'h1; repeat (3) tick();
    ev = '0;
    rd(12'hB03, 32'h1, "wrap_low");
    rd(12'hB83, 32'h0, "wrap_high");
`ifdef IBEX_HPM_OVF_IRQ_EN
    rd(12'h7C2, 32'h8, "ovf_sticky");
    chk("irq_after_wrap", 64'(irq), 64'd1);
    wr(12'h7C2, 32'h8);
    tick();
    chk("irq_cleared", 64'(irq), 64'd0);
`endif

    // Write beats increment in the same cycle
    ev = 16'h1;
    wr(12'hB03, 32'h100);
    rd(12'hB03, 32'h100, "write_suppress");
    tick();
    rd(12'hB03, 32'h101, "count_resume");
    ev = '0;

    // Unmapped addresses: no hit, zero data, no state change
    csr_we = 1'b1; csr_addr = 12'hB07; csr_wdata = 32'hDEAD_BEEF;
    #1;
    chk("oor_cnt_hit", 64'(csr_hit), 64'd0);
    chk("oor_cnt_rdata", 64'(csr_rdata), 64'd0);
    tick();
    csr_we = 1'b1; csr_addr = 12'h327; csr_wdata = 32'hFFFF;
    #1;
    chk("oor_evt_hit", 64'(csr_hit), 64'd0);
    chk("oor_evt_rdata", 64'(csr_rdata), 64'd0);
    tick();
    csr_we = 1'b0;
    rd(12'hB03, 32'h101, "oor_no_change");
    rd(12'h323, 32'h5, "oor_evt_no_change");

    // Asynchronous reset mid-count
    wr(12'hB03, 32'h1233);
    ev = 16'h1;
    tick();
    rd(12'hB03, 32'h1234, "pre_reset");
    #1 rst = 1'b1;
    #1;
    chk("async_reset_cnt", 64'(csr_rdata), 64'd0);
    chk("async_reset_irq", 64'(irq), 64'd0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    tick();
    rd(12'hB03, 32'h0, "post_reset_inhibited");
    ev = '0;

    // Random CSR traffic against the model
    wr(12'h320, 32'h0);
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 7))
        0, 1:    a = 12'(12'hB03 + $urandom_range(0, NC));
        2:       a = 12'(12'hB83 + $urandom_range(0, NC));
        3:       a = 12'(12'h323 + $urandom_range(0, NC));
        4:       a = 12'h320;
        5:       a = ($urandom_range(0, 1) == 0) ? 12'h7C2 : 12'h7C3;
        6:       a = 12'($urandom);
        default: a = 12'hB03;
      endcase
      csr_addr = a;
      csr_we   = ($urandom_range(0, 3) == 0);
      csr_wdata = $urandom;
      if (a >= 12'hB83 && a < 12'(12'hB83 + NC) && $urandom_range(0, 1) == 0) csr_wdata = 32'hFF;
      if (a >= 12'hB03 && a < 12'(12'hB03 + NC) && $urandom_range(0, 1) == 0)
        csr_wdata = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      if (a == 12'h320 && $urandom_range(0, 3) != 0) csr_wdata = 32'h0;
      if (a == 12'h7C3 && $urandom_range(0, 1) == 0) csr_wdata = 32'hFFFF_FFFF;
      ev = NE'($urandom);
      tick();
    end
    csr_we = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
